gpr_wb_arbiter: RTL and testbench

//  Shares the single GPR write port between two writeback requesters: EXU (ALU/CSR results) and LSU
//  (load returns). Tracks GPRs with an outstanding load in a scoreboard and flags read hazards to decode.

---
 rtl/gpr_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between EXU and LSU writebacks (round-robin on ties),
// tracks registers awaiting a load, and flags decode read hazards.
module gpr_wb_arbiter #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int RW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   // Valid/ready: a transfer happens in a cycle where valid && ready; a requester holds
   // rd/wdata stable while valid && !ready. Ready is combinational from the valids and rr_last.
   input  logic            exu_valid_i,
   output logic            exu_ready_o,
   input  logic [RW-1:0]   exu_rd_i,
   input  logic [XLEN-1:0] exu_wdata_i,
   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [RW-1:0]   lsu_rd_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   input  logic            sb_set_i,
   input  logic [RW-1:0]   sb_rd_i,
   input  logic [RW-1:0]   dec_rs1_i,
   input  logic [RW-1:0]   dec_rs2_i,
   output logic            hazard_o,
   output logic            rf_we_o,
   output logic [RW-1:0]   rf_rd_o,
   output logic [XLEN-1:0] rf_wdata_o,
   output logic [NREG-1:0] sb_busy_o,
   output logic            dbg_rr_last_o
);

   typedef enum logic {
      REQ_EXU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

   req_e            rr_last_q, rr_last_d;
   logic            grant_exu, grant_lsu;
   logic            rf_we_q, rf_we_d;
   logic [RW-1:0]   rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0] sb_busy_q, sb_busy_d;
   logic            haz_rs1, haz_rs2;

   // rr_last only records tie outcomes; a lone requester is granted without moving it.
   always_comb begin
      grant_exu = 1'b0;
      grant_lsu = 1'b0;
      rr_last_d = rr_last_q;
      if (!rst) begin
         if (exu_valid_i && lsu_valid_i) begin
            if (rr_last_q == REQ_LSU) begin
               grant_exu = 1'b1;
               rr_last_d = REQ_EXU;
            end else begin
               grant_lsu = 1'b1;
               rr_last_d = REQ_LSU;
            end
         end else begin
            grant_exu = exu_valid_i;
            grant_lsu = lsu_valid_i;
         end
      end
   end

   assign exu_ready_o = grant_exu;
   assign lsu_ready_o = grant_lsu;

   // A granted write to x0 is consumed but never reaches the register file.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_exu) begin
         rf_we_d    = (exu_rd_i != '0);
         rf_rd_d    = exu_rd_i;
         rf_wdata_d = exu_wdata_i;
      end else if (grant_lsu) begin
         rf_we_d    = (lsu_rd_i != '0);
         rf_rd_d    = lsu_rd_i;
         rf_wdata_d = lsu_wdata_i;
      end
   end

   // Set is applied after clear so a new load to the same rd stays in flight.
   always_comb begin
      sb_busy_d = sb_busy_q;
      if (grant_lsu) begin
         sb_busy_d[lsu_rd_i] = 1'b0;
      end
      if (sb_set_i && (sb_rd_i != '0)) begin
         sb_busy_d[sb_rd_i] = 1'b1;
      end
      sb_busy_d[0] = 1'b0;
   end

   // The registered write lands at the end of this cycle; the file cannot return it yet.
   always_comb begin
      haz_rs1  = (dec_rs1_i != '0) &&
                 (sb_busy_q[dec_rs1_i] || (rf_we_q && (rf_rd_q == dec_rs1_i)));
      haz_rs2  = (dec_rs2_i != '0) &&
                 (sb_busy_q[dec_rs2_i] || (rf_we_q && (rf_rd_q == dec_rs2_i)));
      hazard_o = haz_rs1 || haz_rs2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q  <= REQ_LSU;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         sb_busy_q  <= '0;
      end else begin
         rr_last_q  <= rr_last_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         sb_busy_q  <= sb_busy_d;
      end
   end

   assign rf_we_o       = rf_we_q;
   assign rf_rd_o       = rf_rd_q;
   assign rf_wdata_o    = rf_wdata_q;
   assign sb_busy_o     = sb_busy_q;
   assign dbg_rr_last_o = rr_last_q;

   a_one_grant: assert property (@(posedge clk) !(exu_ready_o && lsu_ready_o));
   a_x0_idle:   assert property (@(posedge clk) !sb_busy_q[0]);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed cases then randomized traffic checked by a reference model
// and an expected-write queue drained by a monitor.
module tb_gpr_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            exu_valid = 1'b0, lsu_valid = 1'b0, sb_set = 1'b0;
  logic [4:0]      exu_rd = '0, lsu_rd = '0, sb_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic [XLEN-1:0] exu_wdata = '0, lsu_wdata = '0;
  logic            exu_ready, lsu_ready, hazard, rf_we, dbg_rr_last;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] sb_busy;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .exu_valid_i(exu_valid), .exu_ready_o(exu_ready), .exu_rd_i(exu_rd), .exu_wdata_i(exu_wdata),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
    .sb_set_i(sb_set), .sb_rd_i(sb_rd), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .hazard_o(hazard), .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wdata_o(rf_wdata),
    .sb_busy_o(sb_busy), .dbg_rr_last_o(dbg_rr_last)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN+4:0] exp_q[$];

  // reference model state
  bit         m_busy[NREG];
  bit         m_exu_won_tie;   // last tie went to EXU; reset: LSU held it, so EXU wins next
  bit         m_pend_we;
  logic [4:0] m_pend_rd;
  bit         m_exu_acc, m_lsu_acc;
  bit         ge, gl, hz;
  logic [NREG-1:0] m_busy_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_hazard(input logic [4:0] r);
    return (r != 0) && (m_busy[r] || (m_pend_we && m_pend_rd == r));
  endfunction

  // Model: predicts readies, scoreboard and hazard; pushes expected register-file writes.
  always begin
    @(negedge clk); #1;
    ge = 0; gl = 0;
    if (!rst) begin
      if (exu_valid && lsu_valid) begin
        ge = !m_exu_won_tie;
        gl = m_exu_won_tie;
      end else begin
        ge = exu_valid;
        gl = lsu_valid;
      end
    end
    for (int i = 0; i < NREG; i++) m_busy_v[i] = m_busy[i];
    hz = reads_hazard(dec_rs1) || reads_hazard(dec_rs2);
    check("exu_ready", 64'(exu_ready), 64'(ge));
    check("lsu_ready", 64'(lsu_ready), 64'(gl));
    check("sb_busy", 64'(sb_busy), 64'(m_busy_v));
    check("hazard", 64'(hazard), 64'(hz));
    m_exu_acc = ge;
    m_lsu_acc = gl;
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      m_exu_won_tie = 0;
      m_pend_we = 0;
    end else begin
      if (exu_valid && lsu_valid) m_exu_won_tie = ge;
      m_pend_we = 0;
      if (ge && exu_rd != 0) begin
        exp_q.push_back({exu_rd, exu_wdata});
        m_pend_we = 1; m_pend_rd = exu_rd;
      end
      if (gl && lsu_rd != 0) begin
        exp_q.push_back({lsu_rd, lsu_wdata});
        m_pend_we = 1; m_pend_rd = lsu_rd;
      end
      if (gl) m_busy[lsu_rd] = 0;
      if (sb_set && sb_rd != 0) m_busy[sb_rd] = 1;
    end
  end

  // Monitor: every register-file write must match the oldest expected write, one cycle later.
  always begin
    @(negedge clk);
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rf_spurious: got write rd=%0d data=%0h expected none at %0t",
                 rf_rd, rf_wdata, $time);
      end else begin
        check("rf_write", 64'({rf_rd, rf_wdata}), 64'(exp_q.pop_front()));
      end
    end else if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rf_missing: got rf_we=%b expected write %0h at %0t", rf_we, exp_q[0], $time);
      exp_q.delete();
    end
  end

  task automatic drive(input bit ev, input logic [4:0] erd, input logic [31:0] ewd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] lwd,
                       input bit st, input logic [4:0] srd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk); #1;
    exu_valid = ev; exu_rd = erd; exu_wdata = ewd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wdata = lwd;
    sb_set = st; sb_rd = srd; dec_rs1 = r1; dec_rs2 = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic do_reset();
    idle(0, 0);
    rst = 1'b1;
    idle(0, 0);
    rst = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk); #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_rf_rd", 64'(rf_rd), 64'd0);
    check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset_sb_busy", 64'(sb_busy), 64'd0);

    // EXU only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0); sample();
    check("t1_exu_ready", 64'(exu_ready), 64'd1);
    idle(0, 0); sample();
    check("t1_rf_we", 64'(rf_we), 64'd1);
    check("t1_rf_rd", 64'(rf_rd), 64'd5);
    check("t1_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);

    // tie alternation out of reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h1111_0001, 1, 2, 32'h2222_0002, 0, 0, 0, 0); sample();
      check("t2_exu_grant", 64'(exu_ready), 64'(i % 2 == 0));
      check("t2_lsu_grant", 64'(lsu_ready), 64'(i % 2 == 1));
      if (i > 0) check("t2_rf_rd", 64'(rf_rd), (i % 2 == 1) ? 64'd1 : 64'd2);
    end
    idle(0, 0); sample();
    check("t2_rf_rd_last", 64'(rf_rd), 64'd2);

    // scoreboard lifecycle on x7
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0); sample();
    idle(7, 0); sample();
    check("t3_hazard_busy", 64'(hazard), 64'd1);
    drive(0, 0, 0, 1, 7, 32'h0000_7777, 0, 0, 7, 0); sample();
    check("t3_lsu_ready", 64'(lsu_ready), 64'd1);
    check("t3_hazard_grant", 64'(hazard), 64'd1);
    idle(7, 0); sample();
    check("t3_busy7_clear", 64'(sb_busy[7]), 64'd0);
    check("t3_hazard_inflight", 64'(hazard), 64'd1);
    idle(7, 0); sample();
    check("t3_hazard_gone", 64'(hazard), 64'd0);

    // x0 handling
    drive(0, 0, 0, 1, 0, 32'hABCD_0000, 1, 0, 0, 0); sample();
    check("t4_lsu_ready", 64'(lsu_ready), 64'd1);
    idle(0, 0); sample();
    check("t4_rf_we", 64'(rf_we), 64'd0);
    check("t4_sb_busy", 64'(sb_busy), 64'd0);
    check("t4_hazard", 64'(hazard), 64'd0);

    // set/clear collision on x9
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); sample();
    drive(0, 0, 0, 1, 9, 32'h9999_0009, 1, 9, 0, 0); sample();
    idle(0, 9); sample();
    check("t5_busy9_kept", 64'(sb_busy[9]), 64'd1);
    drive(0, 0, 0, 1, 9, 32'h9999_1009, 0, 0, 0, 0); sample();
    idle(0, 0); sample();
    check("t5_busy9_cleared", 64'(sb_busy[9]), 64'd0);

    // reset mid-operation
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 0); sample();
    drive(1, 6, 32'h6666_0006, 0, 0, 0, 1, 4, 0, 0); sample();
    drive(1, 10, 32'hA0A0_000A, 0, 0, 0, 0, 0, 3, 4);
    rst = 1'b1; sample();
    check("t6_rf_we_pending", 64'(rf_we), 64'd1);
    check("t6_ready_in_rst", 64'(exu_ready), 64'd0);
    idle(3, 4);
    rst = 1'b0; sample();
    check("t6_rf_we", 64'(rf_we), 64'd0);
    check("t6_sb_busy", 64'(sb_busy), 64'd0);
    check("t6_hazard", 64'(hazard), 64'd0);

    // randomized traffic honouring the hold rule
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!(exu_valid && !m_exu_acc)) begin
        exu_valid = ($urandom_range(0, 2) != 0);
        exu_rd    = 5'($urandom_range(0, 31));
        exu_wdata = $urandom;
      end
      if (!(lsu_valid && !m_lsu_acc)) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
        lsu_wdata = $urandom;
      end
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_rd   = 5'($urandom_range(0, 7));
      dec_rs1 = 5'($urandom_range(0, 9));
      dec_rs2 = 5'($urandom_range(0, 31));
      rst     = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
